// File: rtl/joy_serial_scan.sv
// joy_serial_scan: scans a daisy chain of 74HC165-style shift registers over the user port.
// Define JOY_SERIAL_PRESENT_EN to flag players whose raw samples are all zero as not connected.
module joy_serial_scan #(
  parameter int PLAYERS     = 2,
  parameter int BITS        = 12,
  parameter int CLK_DIV     = 4,
  parameter int SCAN_PERIOD = 50000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      joy_data,
  output logic                      joy_load,
  output logic                      joy_clk,
  output logic [PLAYERS*BITS-1:0]   joystick,
  output logic                      valid,
  output logic                      busy,
  output logic [PLAYERS-1:0]        present
);

  localparam int N  = PLAYERS * BITS;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  localparam logic [PW-1:0] PHASE_LAST   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST     = BW'(N - 1);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(SCAN_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic          high, high_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [TW-1:0] timer, timer_n;
  logic [N-1:0]  shreg;
  logic [N-1:0]  joy_next;
  logic          sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= '0;
      high    <= 1'b0;
      bit_idx <= '0;
      timer   <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      high    <= high_n;
      bit_idx <= bit_n;
      timer   <= timer_n;
    end
  end

  // The last timer decrement and the LOAD decision share one IDLE cycle, so the
  // valid pulse is followed by LOAD exactly SCAN_PERIOD cycles later.
  always_comb begin
    state_n = state;
    phase_n = phase;
    high_n  = high;
    bit_n   = bit_idx;
    timer_n = timer;
    sample  = 1'b0;
    case (state)
      IDLE: begin
        if (!enable) begin
          timer_n = '0;
        end else begin
          if (timer != '0) begin
            timer_n = timer - TW'(1);
          end
          if (timer <= TW'(1)) begin
            state_n = LOAD;
            phase_n = '0;
          end
        end
      end
      LOAD: begin
        if (phase == PHASE_LAST) begin
          state_n = SHIFT;
          phase_n = '0;
          high_n  = 1'b0;
          bit_n   = '0;
        end else begin
          phase_n = phase + PW'(1);
        end
      end
      SHIFT: begin
        if (phase != PHASE_LAST) begin
          phase_n = phase + PW'(1);
        end else begin
          phase_n = '0;
          if (!high) begin
            sample = 1'b1;
            high_n = 1'b1;
          end else begin
            high_n = 1'b0;
            if (bit_idx == BIT_LAST) begin
              state_n = UPDATE;
            end else begin
              bit_n = bit_idx + BW'(1);
            end
          end
        end
      end
      UPDATE: begin
        state_n = IDLE;
        timer_n = TIMER_RELOAD;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state
  // they describe and reach the pins straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      joy_load <= 1'b1;
      joy_clk  <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      joystick <= '0;
    end else begin
      if (sample) begin
        shreg[bit_idx] <= joy_data;
      end
      joy_load <= (state_n != LOAD);
      joy_clk  <= (state_n == SHIFT) && high_n;
      busy     <= (state_n == LOAD) || (state_n == SHIFT);
      valid    <= (state_n == UPDATE);
      if (state_n == UPDATE) begin
        joystick <= joy_next;
      end
    end
  end

`ifdef JOY_SERIAL_PRESENT_EN
  logic [PLAYERS-1:0] present_next;

  // A floating or pulled-low line reads as every button pressed; treat it as unplugged.
  always_comb begin
    joy_next     = ~shreg;
    present_next = '1;
    for (int p = 0; p < PLAYERS; p++) begin
      if (shreg[p*BITS +: BITS] == '0) begin
        present_next[p]         = 1'b0;
        joy_next[p*BITS +: BITS] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      present <= '1;
    end else if (state_n == UPDATE) begin
      present <= present_next;
    end
  end
`else
  assign joy_next = ~shreg;
  assign present  = '1;
`endif

endmodule

// File: tb/tb_joy_serial_scan.sv
// tb_joy_serial_scan: directed checks of joy_serial_scan against a behavioural 74HC165 chain.
// Expected values depend on JOY_SERIAL_PRESENT_EN in the same way as the design.
module tb_joy_serial_scan;

  localparam int N = 24;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          joy_data;
  logic          joy_load;
  logic          joy_clk;
  logic [N-1:0]  joystick;
  logic          valid;
  logic          busy;
  logic [1:0]    present;

  logic          enable2;
  logic          joy_data2;
  logic          joy_load2;
  logic          joy_clk2;
  logic [7:0]    joystick2;
  logic          valid2;
  logic          busy2;
  logic [0:0]    present2;

  logic [N-1:0]  raw;
  logic [7:0]    raw2;
  int            ptr = 0;
  int            ptr2 = 0;

  int checks = 0;
  int failures = 0;

  joy_serial_scan dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .joy_data (joy_data),
    .joy_load (joy_load),
    .joy_clk  (joy_clk),
    .joystick (joystick),
    .valid    (valid),
    .busy     (busy),
    .present  (present)
  );

  joy_serial_scan #(.PLAYERS(1), .BITS(8), .CLK_DIV(1), .SCAN_PERIOD(20)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable2),
    .joy_data (joy_data2),
    .joy_load (joy_load2),
    .joy_clk  (joy_clk2),
    .joystick (joystick2),
    .valid    (valid2),
    .busy     (busy2),
    .present  (present2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain model: LOAD latches the raw pattern, each joy_clk rising edge presents the next bit.
  always @(posedge joy_clk or negedge joy_load) begin
    if (!joy_load) ptr = 0;
    else ptr = ptr + 1;
  end
  assign joy_data = (ptr < N) ? raw[ptr] : 1'b1;

  always @(posedge joy_clk2 or negedge joy_load2) begin
    if (!joy_load2) ptr2 = 0;
    else ptr2 = ptr2 + 1;
  end
  assign joy_data2 = (ptr2 < 8) ? raw2[ptr2] : 1'b1;

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] joy;
    logic [1:0]   pres;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Starts one scan from idle, drops enable during LOAD and returns the cycles up to valid.
  task automatic apply_stimulus(input logic [N-1:0] raw_v, output int len);
    raw = raw_v;
    enable = 1'b1;
    tick();
    check_output("load_start", {31'd0, joy_load}, 32'd0);
    enable = 1'b0;
    len = 1;
    while (!valid && len < 1000) begin
      tick();
      len++;
    end
  endtask

  vec_t vecs[7];
  int   len;
  int   interval;
  int   load_low;
  int   run;
  int   runs;
  int   bad_phase;
  logic prev_clk;
  int   n_valid;
  int   n_load;
  int   n_busy;
  int   n_change;
  logic [N-1:0] held;

  initial begin
    vecs[0] = '{24'h7FFFFE, 24'h800001, 2'b11};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 2'b11};
    vecs[2] = '{24'h5A5A5A, 24'hA5A5A5, 2'b11};
    vecs[6] = '{24'h001FFF, 24'hFFE000, 2'b11};
`ifdef JOY_SERIAL_PRESENT_EN
    vecs[3] = '{24'h000FFF, 24'h000000, 2'b01};
    vecs[4] = '{24'hFFF000, 24'h000000, 2'b10};
    vecs[5] = '{24'h000000, 24'h000000, 2'b00};
`else
    vecs[3] = '{24'h000FFF, 24'hFFF000, 2'b11};
    vecs[4] = '{24'hFFF000, 24'h000FFF, 2'b11};
    vecs[5] = '{24'h000000, 24'hFFFFFF, 2'b11};
`endif

    reset = 1'b1;
    enable = 1'b0;
    enable2 = 1'b0;
    raw = '1;
    raw2 = '1;
    repeat (3) tick();
    check_output("rst_joy_load", {31'd0, joy_load}, 32'd1);
    check_output("rst_joy_clk", {31'd0, joy_clk}, 32'd0);
    check_output("rst_joystick", {8'd0, joystick}, 32'd0);
    check_output("rst_valid", {31'd0, valid}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_present", {30'd0, present}, 32'd3);
    check_output("rst2_joystick", {24'd0, joystick2}, 32'd0);
    check_output("rst2_present", {31'd0, present2}, 32'd1);
    reset = 1'b0;
    repeat (3) tick();

    for (int v = 0; v < 7; v++) begin
      apply_stimulus(vecs[v].raw, len);
      check_output($sformatf("v%0d_scan_len", v), len, 32'd197);
      check_output($sformatf("v%0d_edges", v), ptr, 32'd24);
      check_output($sformatf("v%0d_joystick", v), {8'd0, joystick}, {8'd0, vecs[v].joy});
      check_output($sformatf("v%0d_present", v), {30'd0, present}, {30'd0, vecs[v].pres});
      repeat (5) tick();
    end

    // Steady state: measure one full period between valid pulses.
    raw = 24'h7FFFFE;
    enable = 1'b1;
    len = 0;
    while (!valid && len < 1000) begin
      tick();
      len++;
    end
    check_output("ss_first_valid", {31'd0, valid}, 32'd1);
    interval = 0; load_low = 0; run = 0; runs = 0; bad_phase = 0; prev_clk = 1'b0;
    do begin
      tick();
      interval++;
      if (!joy_load) load_low++;
      if (busy && joy_load) begin
        if (run > 0 && joy_clk == prev_clk) begin
          run++;
        end else begin
          if (run > 0) begin
            runs++;
            if (run != 4) bad_phase++;
          end
          run = 1;
          prev_clk = joy_clk;
        end
      end else if (run > 0) begin
        runs++;
        if (run != 4) bad_phase++;
        run = 0;
      end
    end while (!valid && interval < 60000);
    enable = 1'b0;
    check_output("ss_interval", interval, 32'd50196);
    check_output("ss_load_low", load_low, 32'd4);
    check_output("ss_phase_runs", runs, 32'd48);
    check_output("ss_bad_phase", bad_phase, 32'd0);
    check_output("ss_edges", ptr, 32'd24);
    check_output("ss_joystick", {8'd0, joystick}, 32'h800001);
    repeat (5) tick();

    // Enable dropped at bit 5: scan completes, then the block stays idle.
    raw = 24'h123456;
    enable = 1'b1;
    tick();
    len = 0;
    while (ptr != 5 && len < 500) begin
      tick();
      len++;
    end
    enable = 1'b0;
    n_valid = 0;
    len = 0;
    while (!valid && len < 500) begin
      tick();
      len++;
    end
    check_output("drop_valid", {31'd0, valid}, 32'd1);
    check_output("drop_edges", ptr, 32'd24);
    check_output("drop_joystick", {8'd0, joystick}, 32'hEDCBA9);
    held = joystick;
    n_load = 0; n_busy = 0; n_change = 0;
    repeat (300) begin
      tick();
      if (valid) n_valid++;
      if (!joy_load) n_load++;
      if (busy) n_busy++;
      if (joystick !== held) n_change++;
    end
    check_output("drop_extra_valid", n_valid, 32'd0);
    check_output("drop_extra_load", n_load, 32'd0);
    check_output("drop_busy", n_busy, 32'd0);
    check_output("drop_joy_change", n_change, 32'd0);

    // Reset asserted at bit 10 of a scan.
    raw = 24'h7FFFFE;
    enable = 1'b1;
    tick();
    len = 0;
    while (ptr != 10 && len < 500) begin
      tick();
      len++;
    end
    check_output("mid_reached_bit10", ptr, 32'd10);
    reset = 1'b1;
    #1;
    check_output("mid_rst_joy_load", {31'd0, joy_load}, 32'd1);
    check_output("mid_rst_joy_clk", {31'd0, joy_clk}, 32'd0);
    check_output("mid_rst_joystick", {8'd0, joystick}, 32'd0);
    check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_output("mid_rst_valid", {31'd0, valid}, 32'd0);
    check_output("mid_rst_present", {30'd0, present}, 32'd3);
    tick();
    reset = 1'b0;
    tick();
    check_output("post_rst_load", {31'd0, joy_load}, 32'd0);
    enable = 1'b0;
    len = 1;
    while (!valid && len < 1000) begin
      tick();
      len++;
    end
    check_output("post_rst_scan_len", len, 32'd197);
    check_output("post_rst_edges", ptr, 32'd24);
    check_output("post_rst_joystick", {8'd0, joystick}, 32'h800001);

    // Small configuration: one player, 8 bits, CLK_DIV=1.
    raw2 = 8'h5A;
    enable2 = 1'b1;
    tick();
    check_output("small_load_start", {31'd0, joy_load2}, 32'd0);
    enable2 = 1'b0;
    len = 1;
    while (!valid2 && len < 200) begin
      tick();
      len++;
    end
    check_output("small_scan_len", len, 32'd18);
    check_output("small_edges", ptr2, 32'd8);
    check_output("small_joystick", {24'd0, joystick2}, 32'hA5);
    repeat (5) tick();
    raw2 = 8'h00;
    enable2 = 1'b1;
    tick();
    enable2 = 1'b0;
    len = 1;
    while (!valid2 && len < 200) begin
      tick();
      len++;
    end
    check_output("small0_scan_len", len, 32'd18);
`ifdef JOY_SERIAL_PRESENT_EN
    check_output("small0_joystick", {24'd0, joystick2}, 32'h00);
    check_output("small0_present", {31'd0, present2}, 32'd0);
`else
    check_output("small0_joystick", {24'd0, joystick2}, 32'hFF);
    check_output("small0_present", {31'd0, present2}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
